sync_updn_counter: RTL

Parametrised synchronous up/down modulo counter; successor to the ripple (asynchronous) T-flip-flop down counter. All bits are clocked by the single system clock, so there is no ripple settling. The block adds direction control, count enable, synchronous parallel load, an arbitrary modulus, a wrap/saturate mode and a registered wrap pulse. It is intended as the general-purpose event/timebase counter for datapath and timer blocks.

---
 rtl/cnt_pkg.sv | 21 ++
 rtl/tff_en.sv | 32 +++
 rtl/sync_updn_counter.sv | 99 +++++++++
 3 files changed

// File: rtl/cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnt_pkg
// Description : Shared constants and load-clamp helper for counter blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package cnt_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Limits a requested load value to the highest legal count.
    function automatic logic [31:0] clamp_load(input logic [31:0] i_val,
                                               input logic [31:0] i_max);
        return (i_val > i_max) ? i_max : i_val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tff_en.sv
`default_nettype none
// ============================================================================
// Module      : tff_en
// Description : Rising-edge T flip-flop, asynchronous active-high reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tff_en (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    logic r_bit_q;
    logic w_bit_d;

    always_comb begin
        w_bit_d = r_bit_q ^ t;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_q <= 1'b0;
        end else begin
            r_bit_q <= w_bit_d;
        end
    end

    assign q = r_bit_q;

endmodule
`default_nettype wire

// File: rtl/sync_updn_counter.sv
`default_nettype none
// ============================================================================
// Module      : sync_updn_counter
// Description : Synchronous up/down modulo counter built from T flip-flops,
//               with enable, clamped parallel load, wrap/saturate and wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_updn_counter
    import cnt_pkg::*;
#(
    parameter int N   = 6,
    parameter int MOD = 2 ** N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         sat,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         wrap,
    output logic         zero
);

    if ((N < 2) || (MOD < 2) || (MOD > (2 ** N))) begin : g_mod_check
        $fatal(1, "sync_updn_counter: MOD must lie in 2..2**N and N >= 2");
    end

    localparam logic [N-1:0] c_max = N'(MOD - 1);

    logic [N-1:0] w_q;
    logic [N-1:0] w_q_next;
    logic [N-1:0] w_toggle;
    logic [N-1:0] w_load_val;
    logic [N:0]   w_inc;
    logic [N:0]   w_dec;
    logic         w_at_top;
    logic         w_at_bot;
    logic         w_wrap_d;
    logic         r_wrap_q;

    assign w_load_val = N'(clamp_load(32'(d), 32'(MOD - 1)));
    assign w_inc      = {1'b0, w_q} + {{N{1'b0}}, 1'b1};
    assign w_dec      = {1'b0, w_q} - {{N{1'b0}}, 1'b1};
    // The carry out only fires for a full-range modulus; the compare covers the rest.
    assign w_at_top   = w_inc[N] | (w_q == c_max);
    // Borrow out of the N+1-bit subtraction is set exactly when q is zero.
    assign w_at_bot   = w_dec[N];

    always_comb begin
        w_q_next = w_q;
        w_wrap_d = 1'b0;
        if (load) begin
            w_q_next = w_load_val;
        end else if (en) begin
            if (up == DIR_UP) begin
                if (!w_at_top) begin
                    w_q_next = w_inc[N-1:0];
                end else if (sat == MODE_WRAP) begin
                    w_q_next = '0;
                    w_wrap_d = 1'b1;
                end
            end else begin
                if (!w_at_bot) begin
                    w_q_next = w_dec[N-1:0];
                end else if (sat == MODE_WRAP) begin
                    w_q_next = c_max;
                    w_wrap_d = 1'b1;
                end
            end
        end
    end

    assign w_toggle = w_q ^ w_q_next;

    for (genvar gi = 0; gi < N; gi++) begin : g_tff
        tff_en u_tff (
            .clk (clk),
            .rst (rst),
            .t   (w_toggle[gi]),
            .q   (w_q[gi])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrap_q <= 1'b0;
        end else begin
            r_wrap_q <= w_wrap_d;
        end
    end

    assign q    = w_q;
    assign wrap = r_wrap_q;
    assign zero = (w_q == '0);

endmodule
`default_nettype wire
